// File: rtl/ts_packet_aligner.sv
// ---------------------------------------------------------------------------
// ts_packet_aligner
//
// Finds MPEG-TS packet boundaries in a byte stream that carries a per-byte
// sync flag. It hunts for a flagged SYNC_BYTE, verifies LOCK_COUNT sync bytes
// in a row at packet spacing, and then forwards aligned packets with
// start/end-of-packet markers. UNLOCK_COUNT consecutive bad syncs drop the
// lock, and the search starts again.
//
// Parameters:
//   PKT_LEN      packet length in bytes (>= 2)
//   SYNC_BYTE    expected first byte of every packet
//   LOCK_COUNT   consecutive good syncs needed to lock (>= 2)
//   UNLOCK_COUNT consecutive bad syncs that drop lock (>= 1)
//
// Ports:
//   rclk      in   sole clock
//   rstn      in   asynchronous active-low reset
//   data_in   in   [8] sync flag, [7:0] TS byte
//   valid_in  in   data_in carries a byte this cycle
//   ts_data   out  aligned byte (registered)
//   ts_valid  out  ts_data valid
//   ts_sop    out  first byte of packet, qualified by ts_valid
//   ts_eop    out  last byte of packet, qualified by ts_valid
//   locked    out  high while the aligner is locked
//   err_count out  saturating count of bad syncs seen while locked
//
// Build option: define TS_ERR_CNT_EN to build the err_count counter. If the
// macro is not defined, err_count is tied to zero and no counter is built.
// ---------------------------------------------------------------------------
module ts_packet_aligner #(
  parameter int unsigned PKT_LEN      = 188,
  parameter logic [7:0]  SYNC_BYTE    = 8'h47,
  parameter int unsigned LOCK_COUNT   = 3,
  parameter int unsigned UNLOCK_COUNT = 3
) (
  input  logic        rclk,
  input  logic        rstn,
  input  logic [8:0]  data_in,
  input  logic        valid_in,
  output logic [7:0]  ts_data,
  output logic        ts_valid,
  output logic        ts_sop,
  output logic        ts_eop,
  output logic        locked,
  output logic [15:0] err_count
);

  localparam int unsigned PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BW = $clog2(UNLOCK_COUNT + 1);

  localparam logic [PW-1:0] POS_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] POS_ONE  = PW'(1);
  localparam logic [PW-1:0] POS_LAST = PW'(PKT_LEN - 1);
  localparam logic [GW-1:0] GOOD_TGT = GW'(LOCK_COUNT);
  localparam logic [BW-1:0] BAD_TGT  = BW'(UNLOCK_COUNT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [GW-1:0]   good_q, good_d;
  logic [BW-1:0]   bad_q, bad_d;

  logic [7:0]      ts_data_q;
  logic            ts_valid_q;
  logic            ts_sop_q;
  logic            ts_eop_q;
  logic            locked_q;

  logic            good_sync_s;
  logic            at_sync_s;
  logic            at_last_s;
  logic [PW-1:0]   pos_next_s;
  logic            fwd_s;
  logic            err_inc_s;

  assign good_sync_s = data_in[8] && (data_in[7:0] == SYNC_BYTE);
  assign at_sync_s   = (pos_q == POS_ZERO);
  assign at_last_s   = (pos_q == POS_LAST);
  assign pos_next_s  = at_last_s ? POS_ZERO : (pos_q + POS_ONE);

  // Next-state, counter and forwarding decisions; everything holds when no byte is accepted.
  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    good_d    = good_q;
    bad_d     = bad_q;
    fwd_s     = 1'b0;
    err_inc_s = 1'b0;
    if (valid_in) begin
      case (state_q)
        ST_HUNT: begin
          // The sync byte itself is position 0, so the next byte is position 1.
          if (good_sync_s) begin
            state_d = ST_VERIFY;
            pos_d   = POS_ONE;
            good_d  = GW'(1);
            bad_d   = {BW{1'b0}};
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_VERIFY: begin
          pos_d = pos_next_s;
          if (at_sync_s) begin
            if (good_sync_s) begin
              good_d = good_q + GW'(1);
              if ((good_q + GW'(1)) == GOOD_TGT) begin
                // The sync that completes verification opens the first output packet.
                state_d = ST_LOCKED;
                good_d  = {GW{1'b0}};
                bad_d   = {BW{1'b0}};
                fwd_s   = 1'b1;
              end else begin
                state_d = ST_VERIFY;
              end
            end else begin
              state_d = ST_HUNT;
              pos_d   = POS_ZERO;
              good_d  = {GW{1'b0}};
              bad_d   = {BW{1'b0}};
            end
          end else begin
            state_d = ST_VERIFY;
          end
        end
        ST_LOCKED: begin
          pos_d = pos_next_s;
          fwd_s = 1'b1;
          if (at_sync_s) begin
            if (good_sync_s) begin
              bad_d = {BW{1'b0}};
            end else begin
              err_inc_s = 1'b1;
              bad_d     = bad_q + BW'(1);
              if ((bad_q + BW'(1)) == BAD_TGT) begin
                // Losing lock: this packet is abandoned, and HUNT forwards nothing.
                state_d = ST_HUNT;
                pos_d   = POS_ZERO;
                good_d  = {GW{1'b0}};
                bad_d   = {BW{1'b0}};
                fwd_s   = 1'b0;
              end else begin
                state_d = ST_LOCKED;
              end
            end
          end else begin
            state_d = ST_LOCKED;
          end
        end
        default: begin
          state_d = ST_HUNT;
          pos_d   = POS_ZERO;
          good_d  = {GW{1'b0}};
          bad_d   = {BW{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and alignment counters.
  always_ff @(posedge rclk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_HUNT;
      pos_q   <= POS_ZERO;
      good_q  <= {GW{1'b0}};
      bad_q   <= {BW{1'b0}};
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end

  // Registered output stage; locked follows the state on the same edge.
  always_ff @(posedge rclk or negedge rstn) begin
    if (!rstn) begin
      ts_data_q  <= 8'h00;
      ts_valid_q <= 1'b0;
      ts_sop_q   <= 1'b0;
      ts_eop_q   <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      if (fwd_s) begin
        ts_data_q <= data_in[7:0];
      end else begin
        ts_data_q <= ts_data_q;
      end
      ts_valid_q <= fwd_s;
      ts_sop_q   <= fwd_s && at_sync_s;
      ts_eop_q   <= fwd_s && at_last_s;
      locked_q   <= (state_d == ST_LOCKED);
    end
  end

  assign ts_data  = ts_data_q;
  assign ts_valid = ts_valid_q;
  assign ts_sop   = ts_sop_q;
  assign ts_eop   = ts_eop_q;
  assign locked   = locked_q;

`ifdef TS_ERR_CNT_EN
  logic [15:0] err_q;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'h0001;
    end
  endfunction

  // Bad-sync error counter.
  always_ff @(posedge rclk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 16'h0000;
    end else if (err_inc_s) begin
      err_q <= sat_inc16(err_q);
    end else begin
      err_q <= err_q;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ts_packet_aligner.sv
// Scoreboard bench for ts_packet_aligner: stimulus pushes the expected output
// bytes, and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_ts_packet_aligner;

  localparam int PKT = 188;

  logic        rclk = 1'b0;
  logic        rstn = 1'b0;
  logic [8:0]  data_in = 9'h000;
  logic        valid_in = 1'b0;
  logic [7:0]  ts_data;
  logic        ts_valid;
  logic        ts_sop;
  logic        ts_eop;
  logic        locked;
  logic [15:0] err_count;

  int n_chk  = 0;
  int n_fail = 0;

  // expected {data[7:0], sop, eop}
  logic [9:0] sb[$];

  ts_packet_aligner dut (
    .rclk      (rclk),
    .rstn      (rstn),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ts_data   (ts_data),
    .ts_valid  (ts_valid),
    .ts_sop    (ts_sop),
    .ts_eop    (ts_eop),
    .locked    (locked),
    .err_count (err_count)
  );

  always #5 rclk = ~rclk;

  function automatic logic [15:0] exp_err(input logic [15:0] v);
`ifdef TS_ERR_CNT_EN
    return v;
`else
    return 16'h0000 & v;
`endif
  endfunction

  function automatic logic [7:0] body(input int i);
    logic [7:0] b;
    b = 8'(i) ^ 8'h5A;
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every valid output against the scoreboard head.
  always @(negedge rclk) begin
    if (rstn) begin
      if (ts_valid) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got data %0h sop %0b eop %0b, none expected at %0t",
                   ts_data, ts_sop, ts_eop, $time);
        end else begin
          logic [9:0] e;
          e = sb.pop_front();
          if ({ts_data, ts_sop, ts_eop} !== e) begin
            n_fail++;
            $display("FAIL out_byte: got data %0h sop %0b eop %0b expected data %0h sop %0b eop %0b at %0t",
                     ts_data, ts_sop, ts_eop, e[9:2], e[1], e[0], $time);
          end
        end
      end else begin
        n_chk++;
        if (ts_sop || ts_eop) begin
          n_fail++;
          $display("FAIL sop_eop_unqualified: got sop %0b eop %0b expected 0 0 at %0t", ts_sop, ts_eop, $time);
        end
      end
    end
  end

  // Send one packet. fwd: expect it on the output. lk/er: expected locked and
  // err_count once the first byte has been accepted. gaps: idle cycle after each byte.
  task automatic send_pkt(input logic [8:0] hdr, input bit fwd, input bit lk,
                          input logic [15:0] er, input bit gaps);
    for (int i = 0; i < PKT; i++) begin
      @(posedge rclk); #1;
      if (i == 1) begin
        chk("locked_after_sync", {31'd0, locked}, {31'd0, lk});
        chk("err_after_sync", {16'd0, err_count}, {16'd0, exp_err(er)});
      end
      data_in  = (i == 0) ? hdr : {1'b0, body(i)};
      valid_in = 1'b1;
      if (fwd) sb.push_back({data_in[7:0], (i == 0), (i == PKT - 1)});
      if (gaps) begin
        @(posedge rclk); #1;
        valid_in = 1'b0;
        data_in  = 9'h147;
      end
    end
    @(posedge rclk); #1;
    valid_in = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ts_data"},  {24'd0, ts_data}, 32'd0);
    chk({tag, "_ts_valid"}, {31'd0, ts_valid}, 32'd0);
    chk({tag, "_ts_sop"},   {31'd0, ts_sop}, 32'd0);
    chk({tag, "_ts_eop"},   {31'd0, ts_eop}, 32'd0);
    chk({tag, "_locked"},   {31'd0, locked}, 32'd0);
    chk({tag, "_err"},      {16'd0, err_count}, 32'd0);
  endtask

  initial begin
    #12;
    chk_reset_outputs("reset");
    rstn = 1'b1;
    // idle with a flagged sync present but valid_in low: nothing may happen
    data_in = 9'h147;
    repeat (4) @(posedge rclk);
    #1;
    chk("idle_locked", {31'd0, locked}, 32'd0);

    // acquisition: two packets verified silently, the third is output
    send_pkt(9'h147, 1'b0, 1'b0, 16'd0, 1'b0);
    send_pkt(9'h147, 1'b0, 1'b0, 16'd0, 1'b0);
    send_pkt(9'h147, 1'b1, 1'b1, 16'd0, 1'b0);
    // one bad sync is tolerated and still forwarded with sop
    send_pkt(9'h000, 1'b1, 1'b1, 16'd1, 1'b0);
    // good packet clears the bad count
    send_pkt(9'h147, 1'b1, 1'b1, 16'd1, 1'b0);
    // three bad syncs in a row: the third drops lock and is not forwarded
    send_pkt(9'h047, 1'b1, 1'b1, 16'd2, 1'b0);
    send_pkt(9'h1FF, 1'b1, 1'b1, 16'd3, 1'b0);
    send_pkt(9'h0AA, 1'b0, 1'b0, 16'd4, 1'b0);
    // re-acquire
    send_pkt(9'h147, 1'b0, 1'b0, 16'd4, 1'b0);
    send_pkt(9'h147, 1'b0, 1'b0, 16'd4, 1'b0);
    send_pkt(9'h147, 1'b1, 1'b1, 16'd4, 1'b0);
    // locked stream with valid_in toggling
    send_pkt(9'h147, 1'b1, 1'b1, 16'd4, 1'b1);
    send_pkt(9'h100, 1'b1, 1'b1, 16'd5, 1'b1);

    // reset in the middle of a forwarded packet
    for (int i = 0; i < 5; i++) begin
      @(posedge rclk); #1;
      data_in  = (i == 0) ? 9'h147 : {1'b0, body(i)};
      valid_in = 1'b1;
      if (i < 4) sb.push_back({data_in[7:0], (i == 0), 1'b0});
    end
    @(posedge rclk); #1;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    valid_in = 1'b0;
    @(posedge rclk); #1;
    rstn = 1'b1;
    // first byte after reset is evaluated in HUNT
    send_pkt(9'h147, 1'b0, 1'b0, 16'd0, 1'b0);
    send_pkt(9'h147, 1'b0, 1'b0, 16'd0, 1'b0);
    send_pkt(9'h147, 1'b1, 1'b1, 16'd0, 1'b0);

    repeat (3) @(posedge rclk);
    #1;
    chk("final_locked", {31'd0, locked}, 32'd1);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ts_packet_aligner.md
TS_PACKET_ALIGNER -- requirements
Module: ts_packet_aligner

Interface
REQ-001 Parameter PKT_LEN, default 188: TS packet length in bytes.
REQ-002 Parameter SYNC_BYTE, default 8'h47: expected first byte of every packet.
REQ-003 Parameter LOCK_COUNT, default 3: consecutive good syncs needed to lock.
REQ-004 Parameter UNLOCK_COUNT, default 3: consecutive bad syncs that drop lock.
REQ-005 rclk  input  1  sole clock; the design SHALL have one clock only.
REQ-006 rstn  input  1  reset, asynchronous assert, active-low.
REQ-007 data_in  input  9  [8] sync flag, [7:0] TS byte, from upstream output FIFO.
REQ-008 valid_in  input  1  data_in holds a byte this cycle.
REQ-009 ts_data  output  8  aligned byte.
REQ-010 ts_valid  output  1  ts_data valid.
REQ-011 ts_sop  output  1  first byte of packet, qualified by ts_valid.
REQ-012 ts_eop  output  1  last byte of packet, qualified by ts_valid.
REQ-013 locked  output  1  high while state is LOCKED.
REQ-014 err_count  output  16  count of bad syncs seen while LOCKED.

Function
REQ-015 Byte accepted only when valid_in=1; with valid_in=0 every counter and the state SHALL hold, ts_valid=0.
REQ-016 Good sync: accepted byte with data_in[8]=1 and data_in[7:0]=SYNC_BYTE; anything else at a sync position is bad.
REQ-017 Byte counter counts accepted bytes 0..PKT_LEN-1, wrapping to 0; position 0 is the sync position.
REQ-018 States HUNT, VERIFY, LOCKED; reset state HUNT.
REQ-019 HUNT: good sync -> VERIFY, byte counter=1, good count=1; other bytes ignored.
REQ-020 VERIFY: at position 0, good sync increments good count; reaching LOCK_COUNT -> LOCKED; bad sync -> HUNT with counters cleared; sync flags at positions other than 0 ignored.
REQ-021 LOCKED: good sync clears bad count; bad sync increments bad count and err_count; bad count reaching UNLOCK_COUNT -> HUNT.
REQ-022 Forwarded bytes: every accepted byte while LOCKED, plus the sync byte that causes VERIFY->LOCKED; the bad sync byte causing LOCKED->HUNT and all later bytes of that packet are not forwarded.
REQ-023 Outputs registered: forwarded byte appears on ts_data with ts_valid=1 one rclk after acceptance.
REQ-024 ts_sop=1 for position 0, ts_eop=1 for position PKT_LEN-1, both 0 when ts_valid=0.
REQ-025 locked registered, changes on the same edge as the state.
REQ-026 err_count saturates at 16'hFFFF, never wraps.
REQ-027 Bad sync byte not dropping lock is still forwarded with ts_sop=1.

Reset
REQ-028 rstn=0 SHALL immediately force: state HUNT, all counters 0, ts_data=0, ts_valid=0, ts_sop=0, ts_eop=0, locked=0, err_count=0.
REQ-029 Reset mid-packet discards the partial packet; first accepted byte after release is evaluated in HUNT.

Configuration
REQ-030 Macro TS_ERR_CNT_EN defined: err_count per REQ-021/REQ-026.
REQ-031 Macro TS_ERR_CNT_EN undefined: no counter register built, err_count tied to 16'h0000; all other behaviour identical.

Verification
REQ-032 Reset asserted during traffic -> all outputs 0 next sample, locked=0, state HUNT.
REQ-033 Three clean 188-byte packets, first byte 0x47 with flag=1, valid_in=1 continuous -> locked=1 one cycle after third sync; packets 1-2 not output; packet 3 output with sop on 0x47, eop on byte 188.
REQ-034 Locked, one packet with first byte 0x00 -> err_count=1, locked stays 1, packet forwarded with sop; next good packet clears bad count.
REQ-035 Locked, three consecutive packets with bad sync -> err_count=3, locked=0 after third, third packet bytes not output, ts_valid=0 until relock.
REQ-036 Locked stream with valid_in toggling 1/0 -> identical byte sequence out, ts_valid high only one cycle after each valid_in=1, sop/eop positions unchanged.
REQ-037 TS_ERR_CNT_EN undefined, rerun REQ-035 stimulus -> err_count=0, locked drops identically.
